store_buffer: RTL

//  - Holds committed stores in FIFO order and drains them one at a time

---
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer.sv | 115 +++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Bus bundle between the store buffer, the commit stage, the load/store arbiter
// and the load path. The buffer takes the slave side; the surrounding logic takes the master side.
interface store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              st_vld;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              str_req;
   logic              str_grnt;
   logic              done;
   logic [ADDR_W-1:0] str_addr;
   logic [DATA_W-1:0] str_data;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_hazard;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   modport master (
      output st_vld, st_addr, st_data, str_grnt, done, ld_addr,
      input  full, empty, count, str_req, str_addr, str_data,
             ld_hazard, fwd_hit, fwd_data
   );

   modport slave (
      input  st_vld, st_addr, st_data, str_grnt, done, ld_addr,
      output full, empty, count, str_req, str_addr, str_data,
             ld_hazard, fwd_hit, fwd_data
   );
endinterface

// File: rtl/store_buffer.sv
// FIFO of committed stores drained one at a time through the arbiter, with load
// alias detection. Define STORE_BUF_FWD_EN to forward the youngest matching store's data to loads.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {WAIT, BUSY} drain_state_t;

   drain_state_t      state_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              full_reg;
   logic              empty_reg;
   logic [DEPTH-1:0]  valid_reg;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  match;
   logic              push;
   logic              pop;

   // A pop in the same cycle never frees a slot for a push that arrives while full.
   assign push = bus.st_vld && !full_reg;
   assign pop  = (state_reg == BUSY) && bus.done;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= WAIT;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         valid_reg  <= '0;
      end else begin
         case (state_reg)
            WAIT:    if (bus.str_grnt && !empty_reg) state_reg <= BUSY;
            BUSY:    if (bus.done) state_reg <= WAIT;
            default: state_reg <= WAIT;
         endcase
         if (push) begin
            valid_reg[wr_ptr_reg] <= 1'b1;
            wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            valid_reg[rd_ptr_reg] <= 1'b0;
            rd_ptr_reg            <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_W'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   // Payload storage needs no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= bus.st_addr;
         data_mem[wr_ptr_reg] <= bus.st_data;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign match[gi] = valid_reg[gi] && (addr_mem[gi] == bus.ld_addr);
      end
   endgenerate

   assign bus.full      = full_reg;
   assign bus.empty     = empty_reg;
   assign bus.count     = count_reg;
   assign bus.str_req   = !empty_reg;
   assign bus.str_addr  = addr_mem[rd_ptr_reg];
   assign bus.str_data  = data_mem[rd_ptr_reg];
   assign bus.ld_hazard = |match;

`ifdef STORE_BUF_FWD_EN
   logic [DATA_W-1:0] fwd_data_next;
   logic [PTR_W-1:0]  scan_idx;

   // Scan oldest to youngest so the last hit is the store nearest wr_ptr-1.
   always_comb begin
      fwd_data_next = '0;
      scan_idx      = rd_ptr_reg;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_ptr_reg + PTR_W'(k);
         if (match[scan_idx]) fwd_data_next = data_mem[scan_idx];
      end
   end

   assign bus.fwd_hit  = |match;
   assign bus.fwd_data = fwd_data_next;
`else
   assign bus.fwd_hit  = 1'b0;
   assign bus.fwd_data = '0;
`endif
endmodule
